// File: rtl/dsc_mul_sequencer.sv
// rtl/dsc_mul_sequencer.sv - operand/result sequencer around one stochastic-computing multiplier
// Latches an operand bundle, runs the multiplier until done or watchdog, and holds the captured count.
module dsc_mul_sequencer #(
  parameter int DATA_WIDTH = 5,
  parameter int NUM_INPUTS = 2,
  parameter int RES_WIDTH  = DATA_WIDTH*NUM_INPUTS,
  parameter int TIMEOUT    = 1024
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data,
  output logic [NUM_INPUTS*DATA_WIDTH-1:0] mul_operand,
  output logic                             mul_rst,
  output logic                             mul_en,
  input  logic                             mul_done,
  input  logic [RES_WIDTH-1:0]             mul_result,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [RES_WIDTH-1:0]             out_data,
  output logic                             out_timeout,
  output logic                             busy
);
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT-1);

  typedef enum logic [2:0] {S_IDLE, S_CLEAR, S_RUN, S_DRAIN, S_HOLD} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic          timeout_q, timeout_n;

  assign in_ready = (state == S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      timeout_q <= 1'b0;
    end else begin
      state     <= state_n;
      timeout_q <= timeout_n;
    end
  end

  // The counter==0 cycle ignores mul_done: the multiplier may flag done right after clear.
  always_comb begin
    state_n   = state;
    timeout_n = timeout_q;
    case (state)
      S_IDLE:  if (in_valid) state_n = S_CLEAR;
      S_CLEAR: state_n = S_RUN;
      S_RUN: begin
        if (mul_done && (cnt != '0)) begin
          state_n   = S_DRAIN;
          timeout_n = 1'b0;
        end else if (cnt == CNT_LAST) begin
          state_n   = S_DRAIN;
          timeout_n = 1'b1;
        end
      end
      S_DRAIN: state_n = S_HOLD;
      S_HOLD:  if (out_ready) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (state == S_CLEAR) begin
      cnt <= '0;
    end else if (state_n == S_RUN) begin
      cnt <= cnt + CW'(1);
    end
  end

  // Control outputs are decoded from the next state so they come straight off flops.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mul_rst     <= 1'b1;
      mul_en      <= 1'b0;
      out_valid   <= 1'b0;
      busy        <= 1'b0;
      out_data    <= '0;
      out_timeout <= 1'b0;
      mul_operand <= '0;
    end else begin
      mul_rst   <= (state_n == S_CLEAR);
      mul_en    <= (state_n == S_RUN);
      out_valid <= (state_n == S_HOLD);
      busy      <= (state_n != S_IDLE);
      if (state == S_DRAIN) begin
        out_data    <= mul_result;
        out_timeout <= timeout_q;
      end
      if (in_ready && in_valid) begin
        mul_operand <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_dsc_mul_sequencer.sv
// tb/tb_dsc_mul_sequencer.sv - self-checking bench for dsc_mul_sequencer with a stub multiplier
module tb_dsc_mul_sequencer;
  localparam int DW  = 5;
  localparam int NI  = 2;
  localparam int RW  = DW*NI;
  localparam int TMO = 16;
  localparam int NEVER = 999;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [NI*DW-1:0] in_data;
  logic [NI*DW-1:0] mul_operand;
  logic          mul_rst;
  logic          mul_en;
  logic          mul_done;
  logic [RW-1:0] mul_result;
  logic          out_valid;
  logic          out_ready;
  logic [RW-1:0] out_data;
  logic          out_timeout;
  logic          busy;

  int n_vec = 0;
  int n_err = 0;

  dsc_mul_sequencer #(
    .DATA_WIDTH(DW), .NUM_INPUTS(NI), .RES_WIDTH(RW), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mul_operand(mul_operand), .mul_rst(mul_rst), .mul_en(mul_en),
    .mul_done(mul_done), .mul_result(mul_result),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_timeout(out_timeout), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [RW-1:0] data;
    int           done_at;
    logic [RW-1:0] result;
    int           bp;
    int           exp_lat;
    logic         exp_to;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: done is seen at the first counter value >= max(done_at,1); watchdog ends at TMO-1.
  function automatic int model_lat(input int done_at, output logic to);
    int first;
    first = (done_at < 1) ? 1 : done_at;
    if (first <= TMO-1) begin
      to = 1'b0;
      return first + 4;
    end
    to = 1'b1;
    return (TMO-1) + 4;
  endfunction

  // Entered and left one time unit after a rising edge, with the DUT in IDLE.
  task automatic run_txn(input string name, input logic [RW-1:0] data, input int done_at,
                         input logic [RW-1:0] result, input int bp, input int exp_lat,
                         input logic exp_to);
    int lat, k, rst_cnt, rst_first, en_cnt, en_first;
    logic op_ok, hold_ok, done_ok, to_held;
    logic [RW-1:0] held;
    lat = -1; k = 0; rst_cnt = 0; rst_first = -1; en_cnt = 0; en_first = -1;
    op_ok = 1'b1; hold_ok = 1'b1; done_ok = 1'b0; held = '0; to_held = 1'b0;
    chk({name, "_in_ready_idle"}, in_ready, 1);
    in_valid = 1'b1; in_data = data; mul_result = result; mul_done = 1'b0; out_ready = 1'b0;
    for (int t = 1; t < 200; t++) begin
      @(posedge clk); #1;
      if (t == 1) begin
        in_valid = (bp > 0);
        in_data  = ~data;
      end
      if (mul_operand !== data) op_ok = 1'b0;
      if (mul_rst) begin
        rst_cnt++;
        if (rst_first < 0) rst_first = t;
      end
      mul_done = (k >= done_at);
      if (mul_en) begin
        en_cnt++;
        k++;
        if (en_first < 0) en_first = t;
      end
      if (out_valid && lat < 0) begin
        lat = t; held = out_data; to_held = out_timeout;
      end
      if (lat >= 0) begin
        if (t - lat <= bp) begin
          if (out_data !== held || out_timeout !== to_held || in_ready !== 1'b0 || out_valid !== 1'b1)
            hold_ok = 1'b0;
          if (t - lat == bp) out_ready = 1'b1;
        end else begin
          chk({name, "_in_ready_after"}, in_ready, 1);
          chk({name, "_busy_after"}, busy, 0);
          out_ready = 1'b0; in_valid = 1'b0; mul_done = 1'b0;
          done_ok = 1'b1;
          break;
        end
      end
    end
    chk({name, "_complete"}, done_ok, 1);
    chk({name, "_latency"}, lat, exp_lat);
    chk({name, "_out_data"}, held, result);
    chk({name, "_out_timeout"}, to_held, exp_to);
    chk({name, "_mul_rst_cycles"}, rst_cnt, 1);
    chk({name, "_mul_rst_cycle"}, rst_first, 1);
    chk({name, "_mul_en_first"}, en_first, 2);
    chk({name, "_mul_en_cycles"}, en_cnt, exp_lat - 3);
    chk({name, "_operand_stable"}, op_ok, 1);
    chk({name, "_hold_stable"}, hold_ok, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_t vecs[7];
    logic seen;
    logic [RW-1:0] rd, rr;
    int da, bp, el;
    logic eto;

    vecs[0] = '{"normal",    {5'd12, 5'd20}, 7,     10'h0C4, 0, 11, 1'b0};
    vecs[1] = '{"early",     10'h155,        0,     10'h001, 0, 5,  1'b0};
    vecs[2] = '{"watchdog",  10'h2A3,        NEVER, 10'h3FF, 0, 19, 1'b1};
    vecs[3] = '{"done_last", 10'h0F0,        15,    10'h123, 0, 19, 1'b0};
    vecs[4] = '{"done_one",  10'h3E1,        1,     10'h2B6, 1, 5,  1'b0};
    vecs[5] = '{"backpress", {5'd31, 5'd1},  4,     10'h0AB, 5, 8,  1'b0};
    vecs[6] = '{"late_done", 10'h011,        16,    10'h200, 2, 19, 1'b1};

    rst = 1'b0; in_valid = 1'b1; in_data = 10'h2AA; out_ready = 1'b0;
    mul_done = 1'b0; mul_result = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mul_rst", mul_rst, 1);
    chk("rst_mul_en", mul_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_timeout", out_timeout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_operand", mul_operand, 0);
    chk("rst_in_ready", in_ready, 1);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_mul_en", mul_en, 0);

    for (int i = 0; i < 7; i++)
      run_txn(vecs[i].name, vecs[i].data, vecs[i].done_at, vecs[i].result,
              vecs[i].bp, vecs[i].exp_lat, vecs[i].exp_to);

    // Reset while the run counter is 3 (cycle 5 after accept).
    in_valid = 1'b1; in_data = 10'h1C7; mul_done = 1'b0; mul_result = 10'h3C3;
    chk("midrst_accept_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_en_before", mul_en, 1);
    rst = 1'b0;
    #1;
    chk("midrst_mul_en", mul_en, 0);
    chk("midrst_mul_rst", mul_rst, 1);
    chk("midrst_busy", busy, 0);
    chk("midrst_operand", mul_operand, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 25; t++) begin
      @(posedge clk); #1;
      if (out_valid || busy) seen = 1'b1;
    end
    chk("midrst_no_result", seen, 0);
    run_txn("after_midrst", {5'd12, 5'd20}, 7, 10'h0C4, 0, 11, 1'b0);

    for (int i = 0; i < 20; i++) begin
      rd = RW'($urandom);
      rr = RW'($urandom);
      da = ($urandom_range(0, 5) == 0) ? NEVER : int'($urandom_range(0, 18));
      bp = int'($urandom_range(0, 3));
      el = model_lat(da, eto);
      run_txn($sformatf("rand%0d", i), rd, da, rr, bp, el, eto);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dsc_mul_sequencer.md
# dsc_mul_sequencer

Operand/result sequencer for the deterministic stochastic-computing multiplier (ordered CAS, stride-2 SNGs, parallel-lane accumulator). It accepts a bundle of binary operands over a valid/ready handshake and holds them stable on the multiplier's operand bus. It clears the multiplier, enables it until its done flag or a watchdog fires, then captures the accumulated count. The count is presented downstream over a second valid/ready handshake. It sits directly in front of and behind one multiplier instance, so the multiplier never sees changing operands mid-run.

## Interface
- DATA_WIDTH, 5, operand width (matches multiplier DATA_WIDTH)
- NUM_INPUTS, 2, operand count, 2..5
- RES_WIDTH, DATA_WIDTH*NUM_INPUTS, result width (multiplier countval width)
- TIMEOUT, 1024, max RUN cycles before forced capture; must be ≥2
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  operand bundle valid
- in_ready  out  1  sequencer can accept a bundle
- in_data  in  NUM_INPUTS*DATA_WIDTH  operand i in bits [i*DATA_WIDTH +: DATA_WIDTH]
- mul_operand  out  NUM_INPUTS*DATA_WIDTH  latched operands, same packing, to multiplier bin_data_in
- mul_rst  out  1  active-high clear to multiplier
- mul_en  out  1  multiplier enable
- mul_done  in  1  multiplier done
- mul_result  in  RES_WIDTH  multiplier accumulated count
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  RES_WIDTH  captured count
- out_timeout  out  1  result was captured by the watchdog, not by mul_done
- busy  out  1  high in every state except IDLE

## Operation
- States are IDLE, CLEAR, RUN, DRAIN and HOLD. The state register is reset to IDLE.
- IDLE: in_ready=1, which is a combinational decode of the state. When in_valid & in_ready, latch in_data into the operand register and go to CLEAR.
- CLEAR: mul_rst=1 and mul_en=0 for exactly one cycle. Clear the run counter to 0. Next state is RUN.
- RUN: mul_en=1. The run counter increments every cycle.
  - mul_done is ignored while counter==0. The multiplier can flag done immediately after clear because of its zero-stream term.
  - mul_done=1 with counter≥1 goes to DRAIN with timeout flag 0.
  - If counter==TIMEOUT-1 and mul_done=0, go to DRAIN with timeout flag 1.
  - If done and timeout occur in the same cycle, done wins and the timeout flag is 0.
- DRAIN: mul_en=0 for one cycle, so the accumulator's final registered count settles. At the end of DRAIN, capture mul_result into out_data and the timeout flag into out_timeout. Next state is HOLD.
- HOLD: out_valid=1. out_data and out_timeout stay stable until out_valid & out_ready, then go to IDLE. There is no overlap: in_ready=0 in every state except IDLE.
- mul_operand is driven from the operand register. It changes only on an input handshake, so it is constant from CLEAR through HOLD.
- The run counter is $clog2(TIMEOUT) bits wide and does not wrap within a run.

## Timing
- Reset values while rst=0:
  - mul_rst=1, which holds the multiplier cleared.
  - mul_en=0, out_valid=0, out_data=0, out_timeout=0, busy=0, mul_operand=0.
  - in_ready=1, because the state is IDLE.
- mul_rst, mul_en, out_valid, busy, out_data and out_timeout are registered (flop outputs, no glitches).
- Cycle numbering for one transaction:
  - Cycle 0: input handshake.
  - Cycle 1: CLEAR.
  - Cycles 2..2+n: RUN, where n is the first counter value ≥1 with mul_done=1.
  - Cycle 3+n: DRAIN.
  - Cycle 4+n onward: HOLD with out_valid=1.
- Accept-to-valid latency is therefore n+4 cycles.
- A timeout gives n=TIMEOUT-1.
- On an output handshake in cycle h, the sequencer is in IDLE (in_ready=1) in cycle h+1. The minimum period between accepts is n+5 cycles.
- Reset asserted mid-transaction immediately aborts it: outputs take their reset values and any in-flight result is discarded.

## Test plan
- Reset: hold rst=0 for 3 cycles with in_valid=1 -> no accept; mul_rst=1, mul_en=0, out_valid=0, out_data=0, busy=0. After release, in_ready=1.
- Normal run: in_data={5'd12,5'd20} accepted at cycle 0; stub raises mul_done at counter 7 with mul_result=10'h0C4 -> mul_rst=1 only in cycle 1; mul_en=1 in cycles 2..9; out_valid=1 from cycle 11; out_data=0x0C4; out_timeout=0; mul_operand=={5'd12,5'd20} throughout.
- Early done: stub holds mul_done=1 from the CLEAR cycle onward -> the counter==0 cycle is ignored; DRAIN at cycle 4; out_valid at cycle 5.
- Watchdog: TIMEOUT=16 and mul_done never asserted; mul_result=10'h3FF -> mul_en high for 16 cycles; out_valid at cycle 19; out_data=0x3FF; out_timeout=1. Repeat with mul_done raised exactly at counter 15 -> out_timeout=0.
- Backpressure: out_ready=0 for 5 cycles of HOLD while in_valid=1 with new data -> in_ready=0, out_data stable, mul_operand unchanged. One cycle after out_ready=1, in_ready=1 and the new bundle is accepted.
- Reset mid-RUN: assert rst=0 at counter 3 -> same cycle mul_en=0, mul_rst=1, busy=0; no out_valid after release; the next transaction completes normally.
